// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader,
// also used by the memory and PC logic.
package imem_loader_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    WR   = 3'd3,
    CHK  = 3'd4
  } state_e;

endpackage

// File: rtl/loader_ctrl.sv
// Load sequencer: FSM, remaining-word counter and running XOR checksum.
// Emits one-cycle event strobes that the top-level datapath acts on.
module loader_ctrl
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] len_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              byte_valid_i,
  output state_e            state_o,
  output logic              byte_ready_c_o,
  output logic              start_acc_c_o,
  output logic              hi_xfer_c_o,
  output logic              lo_xfer_c_o,
  output logic              wr_c_o,
  output logic              chk_ok_c_o,
  output logic              chk_bad_c_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic              xfer;

  assign state_o        = state_q;
  assign byte_ready_c_o = (state_q == HI) || (state_q == LO) || (state_q == CHK);
  assign xfer           = byte_ready_c_o && byte_valid_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      csum_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      csum_q      <= csum_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    csum_d        = csum_q;
    start_acc_c_o = 1'b0;
    hi_xfer_c_o   = 1'b0;
    lo_xfer_c_o   = 1'b0;
    wr_c_o        = 1'b0;
    chk_ok_c_o    = 1'b0;
    chk_bad_c_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          // A length of zero encodes a full-memory load.
          remaining_d   = (len_i == '0) ? CNT_W'(DEPTH) : CNT_W'(len_i);
          csum_d        = '0;
          start_acc_c_o = 1'b1;
          state_d       = HI;
        end
      end
      HI: begin
        if (xfer) begin
          csum_d      = csum_q ^ byte_i;
          hi_xfer_c_o = 1'b1;
          state_d     = LO;
        end
      end
      LO: begin
        if (xfer) begin
          csum_d      = csum_q ^ byte_i;
          lo_xfer_c_o = 1'b1;
          state_d     = WR;
        end
      end
      WR: begin
        wr_c_o      = 1'b1;
        remaining_d = remaining_q - CNT_W'(1);
        state_d     = (remaining_q == CNT_W'(1)) ? CHK : HI;
      end
      CHK: begin
        if (xfer) begin
          chk_ok_c_o  = (byte_i == csum_q);
          chk_bad_c_o = (byte_i != csum_q);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader top: assembles big-endian words from a byte stream,
// drives the memory write port and holds the core until a clean load completes.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state;
  logic              start_acc, hi_xfer, lo_xfer, wr, chk_ok, chk_bad;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;

  loader_ctrl u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .len_i         (len),
    .byte_i        (byte_in),
    .byte_valid_i  (byte_valid),
    .state_o       (state),
    .byte_ready_c_o(byte_ready),
    .start_acc_c_o (start_acc),
    .hi_xfer_c_o   (hi_xfer),
    .lo_xfer_c_o   (lo_xfer),
    .wr_c_o        (wr),
    .chk_ok_c_o    (chk_ok),
    .chk_bad_c_o   (chk_bad)
  );

  assign imem_we    = (state == WR);
  assign busy       = (state != IDLE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cpu_hold   = hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q       <= '0;
      word_idx_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      hi_q       <= hi_d;
      word_idx_q <= word_idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
    end
  end

  // Address/data are staged on the low-byte transfer so they are valid throughout WR.
  always_comb begin
    hi_d       = hi_q;
    word_idx_d = word_idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = chk_ok;
    err_d      = err_q;
    hold_d     = hold_q;
    if (start_acc) begin
      word_idx_d = '0;
      err_d      = 1'b0;
      hold_d     = 1'b1;
    end
    if (hi_xfer) hi_d = byte_in;
    if (lo_xfer) begin
      wdata_d = {hi_q, byte_in};
      addr_d  = word_idx_q;
    end
    if (wr)      word_idx_d = word_idx_q + ADDR_W'(1);
    if (chk_ok)  hold_d = 1'b0;
    if (chk_bad) err_d = 1'b1;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads with a write scoreboard,
// plus hand-written reset-mid-load sequence.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  len;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  len;
    bit          alt;
    logic [15:0] w0;
    bit          corrupt;
    bit          stall;
    bit          poke;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t  exp_q[$];
  vec_t vecs[7];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (imem_we) begin
        check("ready_low_in_wr", {31'd0, byte_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data 0x%h, no write expected", imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {27'd0, imem_addr}, {27'd0, e.addr});
          check("wr_data", {16'd0, imem_wdata}, {16'd0, e.data});
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int t = 0;
    if (stall) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: byte_ready stayed 0, required 1 within 40 cycles");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic start_load(input logic [4:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    len   = 5'd0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    check("err_cleared_on_start", {31'd0, err}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int          n;
    int          d0;
    logic [7:0]  cs;
    logic [15:0] w;
    n  = (v.len == 5'd0) ? 32 : int'(v.len);
    d0 = done_cnt;
    cs = 8'h00;
    start_load(v.len);
    for (int i = 0; i < n; i++) begin
      w = v.alt ? (((i % 2) == 1) ? ~v.w0 : v.w0) : v.w0 + 16'(i);
      send_byte(w[15:8], v.stall);
      if (v.poke && i == 0) begin
        start = 1'b1;
        len   = 5'd5;
        @(negedge clk);
        start = 1'b0;
        len   = 5'd0;
      end
      exp_q.push_back('{addr: 5'(i), data: w});
      send_byte(w[7:0], v.stall);
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    send_byte(v.corrupt ? ~cs : cs, v.stall);
    @(negedge clk);
    check("done_pulses", done_cnt - d0, {31'd0, v.exp_done});
    check("done_is_pulse", {31'd0, done}, 32'd0);
    check("err_flag", {31'd0, err}, {31'd0, v.exp_err});
    check("cpu_hold_end", {31'd0, cpu_hold}, {31'd0, !v.exp_done});
    check("busy_end", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("writes_drained", exp_q.size(), 32'd0);
    check("err_sticky", {31'd0, err}, {31'd0, v.exp_err});
  endtask

  initial begin
    logic [15:0] w;
    rst        = 1'b1;
    start      = 1'b0;
    len        = 5'd0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    fork
      monitor();
    join_none

    vecs[0] = '{5'd1,  1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{5'd0,  1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{5'd2,  1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{5'd2,  1'b0, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{5'd3,  1'b0, 16'h7000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{5'd31, 1'b1, 16'h0F3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{5'd1,  1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_imem_addr", {27'd0, imem_addr}, 32'd0);
    check("rst_imem_wdata", {16'd0, imem_wdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Reset asserted while waiting for the low byte of word 1.
    start_load(5'd2);
    w = 16'hC0DE;
    exp_q.push_back('{addr: 5'd0, data: w});
    send_byte(w[15:8], 1'b0);
    send_byte(w[7:0], 1'b0);
    send_byte(8'h55, 1'b0);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("midrst_imem_we", {31'd0, imem_we}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_writes", exp_q.size(), 32'd0);
    @(negedge clk);
    run_vec(vecs[6]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
